bitcoin_nonce_sched: RTL and testbench

- Schedules a sweep of nonces across `NUM_WORKERS` parallel SHA-256 double-hash workers and collects each worker's final digest word.
- Owns the single result-memory write port: each digest is written to `output_addr + nonce`.
- Sits between the top-level start/done handshake and the hash-worker array, replacing per-worker nonce loops and memory writes.

---
 rtl/bitcoin_nonce_sched.sv | 196 +++++++++++++++++++
 tb/tb_bitcoin_nonce_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_nonce_sched.sv
// rtl/bitcoin_nonce_sched.sv - round-robin nonce dispatch, digest collection and result write-back
// Optional per-worker watchdog: BITCOIN_NONCE_SCHED_WDOG_EN
module bitcoin_nonce_sched #(
    parameter int NUM_WORKERS = 4,
    parameter int NONCE_COUNT = 16,
    parameter int WDOG_CYCLES = 512
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [15:0]               output_addr,
    output logic                      done,
    output logic [NUM_WORKERS-1:0]    wk_start,
    output logic [32*NUM_WORKERS-1:0] wk_nonce,
    output logic [NUM_WORKERS-1:0]    wk_abort,
    input  logic [NUM_WORKERS-1:0]    wk_done,
    input  logic [32*NUM_WORKERS-1:0] wk_result,
    output logic                      mem_we,
    output logic [15:0]               mem_addr,
    output logic [31:0]               mem_write_data,
    output logic                      err
);
    localparam int PW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
    localparam int CW = 9;

    if (NUM_WORKERS < 1 || NUM_WORKERS > 8 || NONCE_COUNT < 1 || NONCE_COUNT > 256 ||
        WDOG_CYCLES < 1) begin : g_bad_param
        $error("bitcoin_nonce_sched: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_base;
    logic [CW-1:0]    r_next_nonce;
    logic [CW-1:0]    r_written;
    logic [NUM_WORKERS-1:0] r_busy;
    logic [NUM_WORKERS-1:0] r_pending;
    logic [PW-1:0]    r_disp_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [31:0]      r_nonce  [NUM_WORKERS];
    logic [31:0]      r_result [NUM_WORKERS];
    logic             r_err;

    logic             w_accept;
    logic             w_disp_fire;
    logic [PW-1:0]    w_disp_idx;
    logic [PW-1:0]    w_disp_cand;
    logic             w_wr_fire;
    logic [PW-1:0]    w_wr_idx;
    logic [PW-1:0]    w_wr_cand;
    logic [NUM_WORKERS-1:0] w_abort;

    assign w_accept = (r_state == S_IDLE) && start;

    // Both arbiters pick the first candidate at or after their own pointer.
    always_comb begin
        w_disp_fire = 1'b0;
        w_disp_idx  = '0;
        w_disp_cand = '0;
        w_wr_fire   = 1'b0;
        w_wr_idx    = '0;
        w_wr_cand   = '0;
        if (r_state == S_RUN) begin
            for (int k = 0; k < NUM_WORKERS; k++) begin
                w_disp_cand = PW'((int'(r_disp_ptr) + k) % NUM_WORKERS);
                if (!w_disp_fire && !r_busy[w_disp_cand] && !r_pending[w_disp_cand] &&
                    (r_next_nonce < CW'(NONCE_COUNT))) begin
                    w_disp_fire = 1'b1;
                    w_disp_idx  = w_disp_cand;
                end
                w_wr_cand = PW'((int'(r_wr_ptr) + k) % NUM_WORKERS);
                if (!w_wr_fire && r_pending[w_wr_cand]) begin
                    w_wr_fire = 1'b1;
                    w_wr_idx  = w_wr_cand;
                end
            end
        end
    end

    always_comb begin
        wk_start = '0;
        wk_nonce = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            wk_start[i] = w_disp_fire && (w_disp_idx == PW'(i));
            wk_nonce[32*i +: 32] = wk_start[i] ? 32'(r_next_nonce) : r_nonce[i];
        end
    end

    always_comb begin
        mem_we         = w_wr_fire;
        mem_addr       = '0;
        mem_write_data = '0;
        if (w_wr_fire) begin
            mem_addr       = r_base + r_nonce[w_wr_idx][15:0];
            mem_write_data = r_result[w_wr_idx];
        end
    end

    assign done     = (r_state == S_FIN);
    assign err      = r_err;
    assign wk_abort = w_abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_wr_fire && (r_written + CW'(1) == CW'(NONCE_COUNT))) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_next_nonce <= '0;
            r_written    <= '0;
            r_busy       <= '0;
            r_pending    <= '0;
            r_disp_ptr   <= '0;
            r_wr_ptr     <= '0;
            r_err        <= 1'b0;
            for (int i = 0; i < NUM_WORKERS; i++) begin
                r_nonce[i]  <= '0;
                r_result[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_base       <= output_addr;
                r_next_nonce <= '0;
                r_written    <= '0;
                r_busy       <= '0;
                r_pending    <= '0;
                r_disp_ptr   <= '0;
                r_wr_ptr     <= '0;
                r_err        <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_WORKERS; i++) begin
                    // A timeout wins over a completion arriving in the same cycle.
                    if (w_abort[i]) begin
                        r_busy[i]    <= 1'b0;
                        r_pending[i] <= 1'b1;
                        r_result[i]  <= 32'hDEADBEEF;
                        r_err        <= 1'b1;
                    end else if (wk_done[i]) begin
                        if (r_busy[i]) begin
                            r_result[i]  <= wk_result[32*i +: 32];
                            r_busy[i]    <= 1'b0;
                            r_pending[i] <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    if (wk_start[i]) begin
                        r_busy[i]  <= 1'b1;
                        r_nonce[i] <= 32'(r_next_nonce);
                    end
                    if (w_wr_fire && (w_wr_idx == PW'(i))) r_pending[i] <= 1'b0;
                end
                if (w_disp_fire) begin
                    r_next_nonce <= r_next_nonce + CW'(1);
                    r_disp_ptr   <= PW'((int'(w_disp_idx) + 1) % NUM_WORKERS);
                end
                if (w_wr_fire) begin
                    r_written <= r_written + CW'(1);
                    r_wr_ptr  <= PW'((int'(w_wr_idx) + 1) % NUM_WORKERS);
                end
            end
        end
    end

`ifdef BITCOIN_NONCE_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] r_wdog [NUM_WORKERS];

    always_comb begin
        w_abort = '0;
        for (int i = 0; i < NUM_WORKERS; i++)
            w_abort[i] = r_busy[i] && (r_wdog[i] == WW'(WDOG_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (reset || w_accept || wk_start[i]) r_wdog[i] <= '0;
            else if (r_busy[i])                   r_wdog[i] <= r_wdog[i] + WW'(1);
        end
    end
`else
    assign w_abort = '0;
`endif

endmodule

// File: tb/tb_bitcoin_nonce_sched.sv
// tb/tb_bitcoin_nonce_sched.sv - scoreboard bench with behavioural worker model for bitcoin_nonce_sched
module tb_bitcoin_nonce_sched;
    localparam int NW = 4;
    localparam int NC = 16;
    localparam int WD = 64;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [15:0]       output_addr;
    logic              done, err, mem_we;
    logic [NW-1:0]     wk_start, wk_abort, wk_done;
    logic [32*NW-1:0]  wk_nonce, wk_result;
    logic [15:0]       mem_addr;
    logic [31:0]       mem_write_data;

    bitcoin_nonce_sched #(.NUM_WORKERS(NW), .NONCE_COUNT(NC), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .reset(reset), .start(start), .output_addr(output_addr), .done(done),
        .wk_start(wk_start), .wk_nonce(wk_nonce), .wk_abort(wk_abort), .wk_done(wk_done),
        .wk_result(wk_result), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
    wr_t         exp_q[$];
    logic [15:0] wlog_addr[$];
    int          wlog_cyc[$];

    int total = 0, bad = 0;
    logic [15:0] base;
    int  next_nonce_m, t0, writes, dones, last_wr_cyc, aborts, rel_cyc;
    int  lat[NW], cnt[NW], nonce_m[NW], abort_due[NW], nonce_owner[256];
    logic [31:0] res_m[NW];
    bit  busy_m[NW], out_m[NW], mute[NW];
    bit  quiet, hold, rel, spur_req, rand_mode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Worker model: answers each dispatch after a latency with a result chosen here.
    initial begin
        bit fire;
        wk_done = '0;
        wk_result = '0;
        forever begin
            @(negedge clk);
            wk_done = '0;
            if (quiet) begin
                for (int i = 0; i < NW; i++) begin busy_m[i] = 0; out_m[i] = 0; end
            end else begin
                if (wk_start != '0) chk("one_dispatch_per_cycle", $countones(wk_start), 1);
                for (int i = 0; i < NW; i++) begin
                    fire = 0;
                    if (wk_start[i]) begin
                        chk("dispatch_nonce", wk_nonce[32*i +: 32], 32'(next_nonce_m));
                        chk("dispatch_worker_free", {31'b0, out_m[i]}, 0);
                        if (next_nonce_m < NW) begin
                            chk("first_round_worker", i, next_nonce_m);
                            chk("first_round_cycle", cyc, t0 + 1 + next_nonce_m);
                        end
                        nonce_m[i] = next_nonce_m;
                        nonce_owner[next_nonce_m % 256] = i;
                        res_m[i] = rand_mode ? $urandom : 32'h1000 + next_nonce_m;
                        cnt[i] = rand_mode ? $urandom_range(12, 1) : lat[i];
                        busy_m[i] = 1;
                        out_m[i] = 1;
                        if (mute[i]) begin
                            exp_q.push_back('{16'(base + next_nonce_m), 32'hDEADBEEF});
                            abort_due[i] = cyc + WD;
                        end
                        next_nonce_m++;
                    end else if (busy_m[i] && !mute[i]) begin
                        if (hold) fire = rel;
                        else begin cnt[i]--; fire = (cnt[i] == 0); end
                        if (fire) begin
                            wk_done[i] = 1'b1;
                            wk_result[32*i +: 32] = res_m[i];
                            busy_m[i] = 0;
                            exp_q.push_back('{16'(base + nonce_m[i]), res_m[i]});
                        end
                    end
                end
                if (rel) begin rel_cyc = cyc; rel = 0; hold = 0; end
                if (spur_req) begin
                    wk_done[2] = 1'b1;
                    wk_result[95:64] = 32'hBAD0BAD0;
                    spur_req = 0;
                end
            end
        end
    end

    // Monitor: every write must match an outstanding expectation.
    initial begin
        int idx;
        int nn;
        forever begin
            @(negedge clk);
            if (wk_abort != '0) begin
                aborts++;
                for (int i = 0; i < NW; i++)
                    if (wk_abort[i]) begin
                        chk("abort_muted_worker", {31'b0, mute[i]}, 1);
                        chk("abort_cycle", cyc, abort_due[i]);
                    end
            end
            if (mem_we) begin
                idx = -1;
                for (int j = 0; j < exp_q.size(); j++)
                    if (idx < 0 && exp_q[j].addr == mem_addr) idx = j;
                chk("write_expected", {31'b0, idx >= 0}, 1);
                if (idx >= 0) begin
                    chk("write_data", mem_write_data, exp_q[idx].data);
                    exp_q.delete(idx);
                    nn = int'(16'(mem_addr - base));
                    if (nn < NC) out_m[nonce_owner[nn]] = 0;
                end
                writes++;
                last_wr_cyc = cyc;
                wlog_addr.push_back(mem_addr);
                wlog_cyc.push_back(cyc);
            end
            if (done) begin
                dones++;
                chk("done_after_last_write", cyc, last_wr_cyc + 1);
                chk("writes_at_done", writes, NC);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, {31'b0, done}, 0);
        chk({tag, "_err"}, {31'b0, err}, 0);
        chk({tag, "_mem_we"}, {31'b0, mem_we}, 0);
        chk({tag, "_mem_addr"}, {16'b0, mem_addr}, 0);
        chk({tag, "_mem_data"}, mem_write_data, 0);
        chk({tag, "_wk_start"}, {28'b0, wk_start}, 0);
        chk({tag, "_wk_abort"}, {28'b0, wk_abort}, 0);
        chk({tag, "_wk_nonce_zero"}, {31'b0, wk_nonce == '0}, 1);
    endtask

    task automatic start_sweep(input logic [15:0] b);
        @(negedge clk); #1;
        base = b;
        output_addr = b;
        writes = 0;
        dones = 0;
        next_nonce_m = 0;
        exp_q.delete();
        t0 = cyc;
        quiet = 0;
        start = 1;
        @(negedge clk); #1;
        start = 0;
    endtask

    task automatic finish_sweep(input bit exp_err);
        for (int k = 0; k < 3000 && dones == 0; k++) @(negedge clk);
        chk("sweep_completed", {31'b0, dones > 0}, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("writes", writes, NC);
        chk("done_pulses", dones, 1);
        chk("err", {31'b0, err}, {31'b0, exp_err});
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        bit f_ffff, f_0000;
        reset = 1; start = 0; output_addr = '0;
        quiet = 1; hold = 0; rel = 0; spur_req = 0; rand_mode = 0; aborts = 0;
        for (int i = 0; i < NW; i++) begin lat[i] = 20; mute[i] = 0; end
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #1 reset = 0;

        // Fixed 20-cycle latency, result = nonce + 0x1000
        start_sweep(16'h0040);
        finish_sweep(0);

        // All four workers complete together
        hold = 1;
        start_sweep(16'h0100);
        for (int k = 0; k < 100 && next_nonce_m < NW; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        n0 = wlog_addr.size();
        rel = 1;
        for (int k = 0; k < 20 && wlog_addr.size() < n0 + 4; k++) @(negedge clk);
        chk("burst_writes_seen", {31'b0, wlog_addr.size() >= n0 + 4}, 1);
        if (wlog_addr.size() >= n0 + 4)
            for (int j = 0; j < 4; j++) begin
                chk("burst_order_addr", {16'b0, wlog_addr[n0 + j]}, {16'b0, 16'(16'h0100 + j)});
                chk("burst_write_cycle", wlog_cyc[n0 + j], rel_cyc + 1 + j);
            end
        finish_sweep(0);

        // Address wrap with random latency and data
        rand_mode = 1;
        n0 = wlog_addr.size();
        start_sweep(16'hFFFE);
        finish_sweep(0);
        f_ffff = 0; f_0000 = 0;
        for (int j = n0; j < wlog_addr.size(); j++) begin
            if (wlog_addr[j] == 16'hFFFF) f_ffff = 1;
            if (wlog_addr[j] == 16'h0000) f_0000 = 1;
        end
        chk("wrap_ffff_written", {31'b0, f_ffff}, 1);
        chk("wrap_0000_written", {31'b0, f_0000}, 1);
        for (int r = 0; r < 2; r++) begin
            start_sweep(16'($urandom));
            finish_sweep(0);
        end
        rand_mode = 0;

        // Spurious completion from idle worker 2
        lat[2] = 3;
        start_sweep(16'h0200);
        for (int k = 0; k < 2000 && !(next_nonce_m == NC && !busy_m[2] && !out_m[2] &&
             (busy_m[0] || busy_m[1] || busy_m[3])); k++) @(negedge clk);
        chk("spurious_window_found", {31'b0, next_nonce_m == NC && !busy_m[2] && !out_m[2] && dones == 0}, 1);
        #1 spur_req = 1;
        finish_sweep(1);
        lat[2] = 20;

        // Reset in the middle of a sweep, then a fresh sweep
        start_sweep(16'h0300);
        for (int k = 0; k < 2000 && writes < 5; k++) @(negedge clk);
        chk("reached_5_writes", {31'b0, writes >= 5}, 1);
        #1;
        chk("nonce_held_before_reset", {31'b0, wk_nonce != '0}, 1);
        quiet = 1;
        reset = 1;
        @(negedge clk); #1;
        chk_all_zero("midreset");
        reset = 0;
        start_sweep(16'h0300);
        finish_sweep(0);

`ifdef BITCOIN_NONCE_SCHED_WDOG_EN
        // Worker 1 never answers; the watchdog fills its slots
        mute[1] = 1;
        start_sweep(16'h0400);
        finish_sweep(1);
        chk("abort_seen", {31'b0, aborts > 0}, 1);
        mute[1] = 0;
`else
        chk("no_abort_without_wdog", aborts, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
